// File: rtl/pipe_pkg.sv
// pipe_pkg: shared bubble constant and per-boundary payload types for the pipelined CPU
package pipe_pkg;
  localparam logic [63:0] DEFAULT_BUBBLE = '0;
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
  } id_ex_t;
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
  } ex_mem_t;
  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
  } mem_wb_t;
endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one-entry payload register with load/clear; clear wins and loads the bubble
module pipe_skid_slot import pipe_pkg::*; #(
  parameter int W = 64,
  parameter logic [W-1:0] BUBBLE = W'(DEFAULT_BUBBLE)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  // entry register: reset/clear empties to bubble, load captures a beat, otherwise hold
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      valid <= 1'b0;
      q     <= BUBBLE;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline boundary register with stall, flush and optional skid slot (PIPE_STAGE_SKID_EN)
module pipe_stage import pipe_pkg::*; #(
  parameter int DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(DEFAULT_BUBBLE)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  input  logic              stall_i,
  input  logic              flush_i
);
  logic              valid_q, main_load, main_clear, accept, drain;
  logic [DATA_W-1:0] main_d;
  assign valid_o = valid_q & ~stall_i;
  assign drain   = valid_o & ready_i;
  assign accept  = valid_i & ready_o & ~flush_i;
`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid, skid_load, skid_clear;
  logic [DATA_W-1:0] skid_data;
  assign ready_o = ~rst_i & (flush_i | (~skid_valid & ~stall_i));
  // two-entry FIFO control: skid refills main on drain, overflow beats park in skid
  always_comb begin
    main_d     = skid_valid ? skid_data : data_i;
    main_load  = ~flush_i & ((drain & (skid_valid | accept)) | (~valid_q & accept));
    main_clear = flush_i | (drain & ~skid_valid & ~accept);
    skid_load  = ~flush_i & accept & valid_q & ~drain;
    skid_clear = flush_i | (drain & skid_valid);
  end
  pipe_skid_slot #(.W(DATA_W), .BUBBLE(BUBBLE)) u_skid (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (data_i),
    .valid (skid_valid),
    .q     (skid_data)
  );
`else
  assign ready_o = ~rst_i & (flush_i | (~stall_i & (~valid_q | ready_i)));
  // single slot: accept loads (covers drain+accept pass-through), lone drain empties
  always_comb begin
    main_d     = data_i;
    main_load  = accept;
    main_clear = flush_i | (drain & ~accept);
  end
`endif
  pipe_skid_slot #(.W(DATA_W), .BUBBLE(BUBBLE)) u_main (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (valid_q),
    .q     (data_o)
  );
endmodule
